// File: rtl/mem_stage_control.sv
// Memory-stage controller: owns the shared memory port for loads/stores, fills the MDR and hands instructions to IR4.
// Optional store-to-load forwarding from the last completed store is enabled by defining MEMCTL_STLD_FWD_EN.
module mem_stage_control #(
  parameter int unsigned     DW       = 8,
  parameter int unsigned     AW       = 8,
  parameter int unsigned     OPW      = 4,
  parameter logic [OPW-1:0]  LOAD_OP  = 4'b0000,
  parameter logic [OPW-1:0]  STORE_OP = 4'b0001,
  parameter int unsigned     MEM_LAT  = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ir3_valid,
  output logic           ir3_ready,
  input  logic [OPW-1:0] ir3_opcode,
  input  logic [AW-1:0]  addr_in,
  input  logic [DW-1:0]  store_data,
  input  logic [DW-1:0]  mem_rdata,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_read,
  output logic           mem_write,
  output logic           mem_busy,
  output logic [DW-1:0]  mdr,
  output logic           ir4_load,
  output logic [OPW-1:0] ir4_opcode
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [AW-1:0]  addr_nxt;
  logic [DW-1:0]  wdata_nxt, mdr_nxt;
  logic           read_nxt, write_nxt, busy_nxt, ir4_load_nxt;
  logic [OPW-1:0] ir4_opcode_nxt;

`ifdef MEMCTL_STLD_FWD_EN
  logic           fwd_valid, fwd_valid_nxt;
  logic [AW-1:0]  fwd_addr, fwd_addr_nxt;
  logic [DW-1:0]  fwd_data, fwd_data_nxt;
  logic           fwd_hit;
  assign fwd_hit = fwd_valid && (addr_in == fwd_addr);
`endif

  assign ir3_ready = (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_busy   <= 1'b0;
      mdr        <= '0;
      ir4_load   <= 1'b0;
      ir4_opcode <= '0;
`ifdef MEMCTL_STLD_FWD_EN
      fwd_valid  <= 1'b0;
      fwd_addr   <= '0;
      fwd_data   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      mem_read   <= read_nxt;
      mem_write  <= write_nxt;
      mem_busy   <= busy_nxt;
      mdr        <= mdr_nxt;
      ir4_load   <= ir4_load_nxt;
      ir4_opcode <= ir4_opcode_nxt;
`ifdef MEMCTL_STLD_FWD_EN
      fwd_valid  <= fwd_valid_nxt;
      fwd_addr   <= fwd_addr_nxt;
      fwd_data   <= fwd_data_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    read_nxt       = mem_read;
    write_nxt      = mem_write;
    busy_nxt       = mem_busy;
    mdr_nxt        = mdr;
    ir4_load_nxt   = 1'b0;
    ir4_opcode_nxt = ir4_opcode;
`ifdef MEMCTL_STLD_FWD_EN
    fwd_valid_nxt  = fwd_valid;
    fwd_addr_nxt   = fwd_addr;
    fwd_data_nxt   = fwd_data;
`endif
    case (state)
      IDLE: begin
        if (ir3_valid) begin
          if (ir3_opcode == LOAD_OP) begin
`ifdef MEMCTL_STLD_FWD_EN
            if (fwd_hit) begin
              mdr_nxt        = fwd_data;
              ir4_load_nxt   = 1'b1;
              ir4_opcode_nxt = LOAD_OP;
            end else begin
`else
            begin
`endif
              state_nxt = RD;
              addr_nxt  = addr_in;
              read_nxt  = 1'b1;
              busy_nxt  = 1'b1;
              cnt_nxt   = 4'(MEM_LAT - 1);
            end
          end else if (ir3_opcode == STORE_OP) begin
            state_nxt = WR;
            addr_nxt  = addr_in;
            wdata_nxt = store_data;
            write_nxt = 1'b1;
            busy_nxt  = 1'b1;
          end else begin
            ir4_load_nxt   = 1'b1;
            ir4_opcode_nxt = ir3_opcode;
          end
        end
      end
      // cnt counts the remaining port cycles; read data is captured on the edge ending the last one
      RD: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          mdr_nxt        = mem_rdata;
          read_nxt       = 1'b0;
          busy_nxt       = 1'b0;
          ir4_load_nxt   = 1'b1;
          ir4_opcode_nxt = LOAD_OP;
          state_nxt      = IDLE;
        end
      end
      WR: begin
        write_nxt      = 1'b0;
        busy_nxt       = 1'b0;
        ir4_load_nxt   = 1'b1;
        ir4_opcode_nxt = STORE_OP;
        state_nxt      = IDLE;
`ifdef MEMCTL_STLD_FWD_EN
        fwd_valid_nxt  = 1'b1;
        fwd_addr_nxt   = mem_addr;
        fwd_data_nxt   = mem_wdata;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_control.sv
// Bench for mem_stage_control: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
// A port-occupancy model is compared against both every cycle, plus directed literal checks.
module tb_mem_stage_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic started = 1'b0;
  always #5 clock = ~clock;

  logic       valid_a, ready_a, rd_a, wr_a, busy_a, ld_a;
  logic [3:0] op_a, iop_a;
  logic [7:0] addr_a, sd_a, rdata_a, maddr_a, wdata_a, mdr_a;
  logic       valid_b, ready_b, rd_b, wr_b, busy_b, ld_b;
  logic [3:0] op_b, iop_b;
  logic [7:0] addr_b, sd_b, rdata_b, maddr_b, wdata_b, mdr_b;

  mem_stage_control #(.DW(8), .AW(8), .OPW(4), .LOAD_OP(4'b0000), .STORE_OP(4'b0001), .MEM_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .ir3_valid(valid_a), .ir3_ready(ready_a), .ir3_opcode(op_a),
    .addr_in(addr_a), .store_data(sd_a), .mem_rdata(rdata_a), .mem_addr(maddr_a), .mem_wdata(wdata_a),
    .mem_read(rd_a), .mem_write(wr_a), .mem_busy(busy_a), .mdr(mdr_a), .ir4_load(ld_a), .ir4_opcode(iop_a));

  mem_stage_control #(.DW(8), .AW(8), .OPW(4), .LOAD_OP(4'b0000), .STORE_OP(4'b0001), .MEM_LAT(3)) dut_b (
    .clock(clock), .reset(reset), .ir3_valid(valid_b), .ir3_ready(ready_b), .ir3_opcode(op_b),
    .addr_in(addr_b), .store_data(sd_b), .mem_rdata(rdata_b), .mem_addr(maddr_b), .mem_wdata(wdata_b),
    .mem_read(rd_b), .mem_write(wr_b), .mem_busy(busy_b), .mdr(mdr_b), .ir4_load(ld_b), .ir4_opcode(iop_b));

  // Memories reload a fixed pattern (addr ^ 0x99) whenever reset is high
  logic [7:0] mema [256];
  logic [7:0] memb [256];
  assign rdata_a = mema[maddr_a];
  assign rdata_b = memb[maddr_b];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mema[i] <= 8'(i) ^ 8'h99;
        memb[i] <= 8'(i) ^ 8'h99;
      end
    end else begin
      if (wr_a) mema[maddr_a] <= wdata_a;
      if (wr_b) memb[maddr_b] <= wdata_b;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  // Model: port occupancy as a remaining-cycle count and the kind of access holding it
  int unsigned m_rem [2];
  int          m_kind [2];
  logic [7:0]  m_addr [2], m_wdata [2], m_mdr [2], m_fa [2], m_fd [2];
  logic [3:0]  m_iop [2];
  logic        m_ld [2], m_fv [2];

  function automatic int unsigned lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic step(input int k, input logic v, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] sd, input logic [7:0] rdat);
    if (reset) begin
      m_rem[k] = 0; m_kind[k] = 0; m_addr[k] = 8'h00; m_wdata[k] = 8'h00; m_mdr[k] = 8'h00;
      m_iop[k] = 4'h0; m_ld[k] = 1'b0; m_fv[k] = 1'b0; m_fa[k] = 8'h00; m_fd[k] = 8'h00;
    end else begin
      m_ld[k] = 1'b0;
      if (m_rem[k] != 0) begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          m_ld[k] = 1'b1;
          if (m_kind[k] == 1) begin
            m_mdr[k] = rdat;
            m_iop[k] = 4'h0;
          end else begin
            m_iop[k] = 4'h1;
            m_fv[k] = 1'b1; m_fa[k] = m_addr[k]; m_fd[k] = m_wdata[k];
          end
        end
      end else if (v) begin
        if (op == 4'h0) begin
`ifdef MEMCTL_STLD_FWD_EN
          if (m_fv[k] && a == m_fa[k]) begin
            m_mdr[k] = m_fd[k]; m_ld[k] = 1'b1; m_iop[k] = 4'h0;
          end else begin
`else
          begin
`endif
            m_rem[k] = lat(k); m_kind[k] = 1; m_addr[k] = a;
          end
        end else if (op == 4'h1) begin
          m_rem[k] = 1; m_kind[k] = 2; m_addr[k] = a; m_wdata[k] = sd;
        end else begin
          m_ld[k] = 1'b1; m_iop[k] = op;
        end
      end
    end
  endtask

  always @(posedge clock) begin
    step(0, valid_a, op_a, addr_a, sd_a, rdata_a);
    step(1, valid_b, op_b, addr_b, sd_b, rdata_b);
  end

  task automatic cmp(input int k, input logic rdy, input logic rd, input logic wr, input logic busy,
                     input logic ld, input logic [7:0] ma, input logic [7:0] wd, input logic [7:0] md,
                     input logic [3:0] io);
    chk("ir3_ready", k, 32'(rdy), 32'(m_rem[k] == 0));
    chk("mem_read", k, 32'(rd), 32'(m_rem[k] != 0 && m_kind[k] == 1));
    chk("mem_write", k, 32'(wr), 32'(m_rem[k] != 0 && m_kind[k] == 2));
    chk("mem_busy", k, 32'(busy), 32'(m_rem[k] != 0));
    chk("ir4_load", k, 32'(ld), 32'(m_ld[k]));
    chk("mem_addr", k, 32'(ma), 32'(m_addr[k]));
    chk("mem_wdata", k, 32'(wd), 32'(m_wdata[k]));
    chk("mdr", k, 32'(md), 32'(m_mdr[k]));
    chk("ir4_opcode", k, 32'(io), 32'(m_iop[k]));
  endtask

  int rdcyc_a = 0, wrcyc_a = 0, ldcnt_a = 0, run_a = 0, maxrun_a = 0;
  int rdcyc_b = 0, busycyc_b = 0, nrdy_b = 0, ldcnt_b = 0;
  logic [7:0] wa_cap = 8'h00, wd_cap = 8'h00;

  always @(negedge clock) begin
    if (started) begin
      cmp(0, ready_a, rd_a, wr_a, busy_a, ld_a, maddr_a, wdata_a, mdr_a, iop_a);
      cmp(1, ready_b, rd_b, wr_b, busy_b, ld_b, maddr_b, wdata_b, mdr_b, iop_b);
      if (rd_a) rdcyc_a++;
      if (wr_a) begin wrcyc_a++; wa_cap = maddr_a; wd_cap = wdata_a; end
      if (ld_a) begin ldcnt_a++; run_a++; if (run_a > maxrun_a) maxrun_a = run_a; end
      else run_a = 0;
      if (rd_b) rdcyc_b++;
      if (busy_b) busycyc_b++;
      if (!ready_b) nrdy_b++;
      if (ld_b) ldcnt_b++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int b_ld, b_rd, b_wr, b_busy, b_nr;

  initial begin
    valid_a = 1'b0; op_a = 4'h0; addr_a = 8'h00; sd_a = 8'h00;
    valid_b = 1'b0; op_b = 4'h0; addr_b = 8'h00; sd_b = 8'h00;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", 0, 32'(ready_a), 32'd1);
    chk("rst_busy", 0, 32'(busy_a), 32'd0);
    chk("rst_mdr", 0, 32'(mdr_a), 32'd0);
    chk("rst_ir4", 1, 32'({ld_b, iop_b}), 32'd0);
    chk("rst_rw", 1, 32'({rd_b, wr_b, busy_b}), 32'd0);

    // three back-to-back non-memory instructions
    b_ld = ldcnt_a; b_rd = rdcyc_a; b_wr = wrcyc_a;
    valid_a = 1'b1; op_a = 4'h5;
    tick(); tick(); tick();
    valid_a = 1'b0;
    tick();
    chk("alu_pulses", 0, 32'(ldcnt_a - b_ld), 32'd3);
    chk("alu_run", 0, 32'(maxrun_a), 32'd3);
    chk("alu_op", 0, 32'(iop_a), 32'd5);
    chk("alu_no_rw", 0, 32'((rdcyc_a - b_rd) + (wrcyc_a - b_wr)), 32'd0);

    // load 0x3C with three-cycle latency; inputs wiggle while busy
    b_ld = ldcnt_b; b_rd = rdcyc_b; b_busy = busycyc_b; b_nr = nrdy_b;
    valid_b = 1'b1; op_b = 4'h0; addr_b = 8'h3C;
    tick();
    valid_b = 1'b0; addr_b = 8'hFF; op_b = 4'h1; sd_b = 8'h11;
    repeat (5) tick();
    chk("ld3_read_cyc", 1, 32'(rdcyc_b - b_rd), 32'd3);
    chk("ld3_busy_cyc", 1, 32'(busycyc_b - b_busy), 32'd3);
    chk("ld3_notready", 1, 32'(nrdy_b - b_nr), 32'd3);
    chk("ld3_mdr", 1, 32'(mdr_b), 32'hA5);
    chk("ld3_pulses", 1, 32'(ldcnt_b - b_ld), 32'd1);
    chk("ld3_addr_hold", 1, 32'(maddr_b), 32'h3C);

    // store 0x5A to 0x10 then load 0x10
    b_ld = ldcnt_a; b_rd = rdcyc_a; b_wr = wrcyc_a;
    valid_a = 1'b1; op_a = 4'h1; addr_a = 8'h10; sd_a = 8'h5A;
    tick();
    valid_a = 1'b0;
    tick();
    valid_a = 1'b1; op_a = 4'h0; addr_a = 8'h10; sd_a = 8'h00;
    tick();
    valid_a = 1'b0;
    repeat (3) tick();
    chk("st_wr_cyc", 0, 32'(wrcyc_a - b_wr), 32'd1);
    chk("st_addr", 0, 32'(wa_cap), 32'h10);
    chk("st_wdata", 0, 32'(wd_cap), 32'h5A);
    chk("stld_mdr", 0, 32'(mdr_a), 32'h5A);
    chk("stld_pulses", 0, 32'(ldcnt_a - b_ld), 32'd2);
`ifdef MEMCTL_STLD_FWD_EN
    chk("stld_rd_cyc", 0, 32'(rdcyc_a - b_rd), 32'd0);
`else
    chk("stld_rd_cyc", 0, 32'(rdcyc_a - b_rd), 32'd1);
`endif

    // reset during the second RD cycle of a three-cycle load
    b_ld = ldcnt_b;
    valid_b = 1'b1; op_b = 4'h0; addr_b = 8'h44;
    tick();
    valid_b = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_read", 1, 32'(rd_b), 32'd0);
    chk("abort_busy", 1, 32'(busy_b), 32'd0);
    chk("abort_ready", 1, 32'(ready_b), 32'd1);
    chk("abort_mdr", 1, 32'(mdr_b), 32'd0);
    repeat (3) tick();
    chk("abort_no_ir4", 1, 32'(ldcnt_b - b_ld), 32'd0);

`ifdef MEMCTL_STLD_FWD_EN
    // forwarded load from the last store address
    b_rd = rdcyc_a;
    valid_a = 1'b1; op_a = 4'h1; addr_a = 8'h20; sd_a = 8'h77;
    tick();
    valid_a = 1'b0;
    tick();
    valid_a = 1'b1; op_a = 4'h0; addr_a = 8'h20;
    tick();
    valid_a = 1'b0;
    chk("fwd_mdr", 0, 32'(mdr_a), 32'h77);
    chk("fwd_ir4", 0, 32'(ld_a), 32'd1);
    chk("fwd_busy", 0, 32'(busy_a), 32'd0);
    tick();
    chk("fwd_no_read", 0, 32'(rdcyc_a - b_rd), 32'd0);
`endif

    // load from an address not recently stored always uses the port
    b_rd = rdcyc_a;
    valid_a = 1'b1; op_a = 4'h0; addr_a = 8'h21;
    tick();
    valid_a = 1'b0;
    repeat (2) tick();
    chk("miss_rd_cyc", 0, 32'(rdcyc_a - b_rd), 32'd1);
    chk("miss_mdr", 0, 32'(mdr_a), 32'hB8);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
